fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, 8, program-counter and memory-address width.
REQ-002 Parameter INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 4].
REQ-003 Parameter TIMEOUT, 15, fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level; leaves IDLE when sampled high.
REQ-007 mem_req  out  1  instruction-read request.
REQ-008 mem_addr  out  PC_W  fetch address, equal to pc.
REQ-009 mem_ack  in  1  one-cycle read completion; mem_rdata valid this cycle.
REQ-010 mem_rdata  in  INSTR_W  fetched instruction.
REQ-011 instr  out  INSTR_W  instruction register.
REQ-012 instr_valid  out  1  one-cycle pulse: instr newly decoded.
REQ-013 exec_done  in  1  execution unit finished the current instruction.
REQ-014 branch_taken  in  1  qualified by exec_done; redirect pc.
REQ-015 branch_target  in  PC_W  new pc when branch_taken.
REQ-016 pc  out  PC_W  current program counter.
REQ-017 halted  out  1  sequencer in HALT.
REQ-018 fault  out  1  sticky fetch-timeout flag.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-020 IDLE->FETCH when start=1; otherwise remain in IDLE.
REQ-021 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; remain until mem_ack=1.
REQ-022 On mem_ack in FETCH: instr <= mem_rdata, go to DECODE; mem_req deasserted from the next cycle.
REQ-023 DECODE SHALL last exactly one cycle with instr_valid=1; opcode 4'hF -> HALT, else -> EXECUTE.
REQ-024 In EXECUTE, on exec_done=1: pc <= branch_target if branch_taken, else pc+1; go to FETCH.
REQ-025 exec_done and branch_taken SHALL be ignored outside EXECUTE.
REQ-026 pc increment SHALL wrap modulo 2^PC_W (8'hFF -> 8'h00).
REQ-027 Minimum instruction latency: mem_ack in the first FETCH cycle plus exec_done in the first EXECUTE cycle gives 3 cycles per instruction.
REQ-028 HALT SHALL be terminal until reset; halted=1 and mem_req=0 in HALT.
REQ-029 mem_ack outside FETCH SHALL be ignored; instr unchanged.

Reset
REQ-030 Reset SHALL force state=IDLE, pc=0, instr=0, mem_req=0, instr_valid=0, halted=0, fault=0, asynchronously.
REQ-031 Reset asserted mid-FETCH or mid-EXECUTE SHALL abandon the operation with no pc update.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on FETCH entry; if TIMEOUT cycles elapse in FETCH without mem_ack, fault <= 1 and state -> HALT.
REQ-033 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, fault SHALL be constant 0, and no counter SHALL be present.
REQ-034 mem_ack in the same cycle the timeout expires SHALL take priority (normal DECODE).

Structure
REQ-035 A shared package SHALL hold the state enumeration, the HALT opcode constant 4'hF, and the default widths.
REQ-036 The pc register with increment/load/wrap SHALL be a sub-module, pc_unit.

Verification
REQ-037 Reset, start=1, mem_ack in the first FETCH cycle with rdata=16'h1234, exec_done one cycle later -> instr=16'h1234, one instr_valid pulse, pc=1, FETCH re-entered.
REQ-038 In EXECUTE: branch_taken=1, branch_target=8'h40, exec_done=1 -> next mem_addr=8'h40.
REQ-039 pc=8'hFF, non-branch exec_done -> pc=8'h00.
REQ-040 Fetch returns 16'hF000 -> halted=1 after DECODE; later start, mem_ack, and exec_done cause no change.
REQ-041 FETCH_TIMEOUT_EN, TIMEOUT=15, no mem_ack -> fault=1 and halted=1 after 15 FETCH cycles; without the macro, still in FETCH after 100 cycles.
REQ-042 reset pulsed mid-EXECUTE with pc=8'h05 -> pc=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state enumeration, HALT opcode and default widths
// for the fetch sequencer. No ports; imported by the interface, pc_unit and the
// top.
package fetch_sequencer_pkg;
  localparam int PC_W_DEF = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam logic [3:0] HALT_OP = 4'hF;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundle of the sequencer's control, memory and execute
// signals.
// Signal names carry the sequencer's point of view (_i into it, _o out of it).
// slave  : the sequencer itself.
// master : the environment (memory, execution unit, controller).
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic start_i, mem_ack_i, exec_done_i, branch_taken_i;
  logic [INSTR_W-1:0] mem_rdata_i, instr_o;
  logic [PC_W-1:0] branch_target_i, mem_addr_o, pc_o;
  logic mem_req_o, instr_valid_o, halted_o, fault_o;
  modport slave (
    input  start_i, mem_ack_i, mem_rdata_i, exec_done_i, branch_taken_i, branch_target_i,
    output mem_req_o, mem_addr_o, instr_o, instr_valid_o, pc_o, halted_o, fault_o
  );
  modport master (
    output start_i, mem_ack_i, mem_rdata_i, exec_done_i, branch_taken_i, branch_target_i,
    input  mem_req_o, mem_addr_o, instr_o, instr_valid_o, pc_o, halted_o, fault_o
  );
endinterface

// File: rtl/fetch_sequencer_pc_unit.sv
// pc_unit: program counter register with increment (wrapping), branch load
// and asynchronous reset to zero.
// Ports: clk_i, rst_i (async, active high), en_i (update this cycle),
// load_i (1: take target_i, 0: increment), target_i, pc_o.
module pc_unit
  import fetch_sequencer_pkg::*;
#(
  parameter int W = PC_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] pc_o
);
  logic [W-1:0] pc_q, pc_d;
  // W-bit addition wraps modulo 2^W on its own
  assign pc_d = load_i ? target_i : pc_q + 1'b1;
  assign pc_o = pc_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pc_q <= '0;
    else if (en_i) pc_q <= pc_d;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/FETCH/DECODE/EXECUTE/HALT instruction sequencer.
// Ports: clk_i, reset_i (async, active high), bus (fetch_sequencer_if.slave):
//   start_i, mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i (instruction read),
//   instr_o/instr_valid_o (decoded instruction, one-cycle pulse),
//   exec_done_i/branch_taken_i/branch_target_i (execute completion),
//   pc_o, halted_o, fault_o.
// Build option: FETCH_TIMEOUT_EN adds a fetch watchdog of TIMEOUT cycles that
// sets the sticky fault flag and halts; without it fault_o is tied to 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk_i,
  input logic reset_i,
  fetch_sequencer_if.slave bus
);
  state_t state_q;
  logic [INSTR_W-1:0] instr_q;
  logic mem_req_q, instr_valid_q, halted_q;
  logic [PC_W-1:0] pc;
  logic pc_en;
  // exec_done/branch are only meaningful while executing
  assign pc_en = state_q == S_EXECUTE && bus.exec_done_i;
  pc_unit #(.W(PC_W)) u_pc (
    .clk_i(clk_i),
    .rst_i(reset_i),
    .en_i(pc_en),
    .load_i(bus.branch_taken_i),
    .target_i(bus.branch_target_i),
    .pc_o(pc)
  );
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic fault_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      mem_req_q <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start_i) begin
          state_q <= S_FETCH;
          mem_req_q <= 1'b1;
          cnt_q <= '0;
        end
        // mem_ack wins over a watchdog expiring in the same cycle
        S_FETCH: if (bus.mem_ack_i) begin
          instr_q <= bus.mem_rdata_i;
          state_q <= S_DECODE;
          mem_req_q <= 1'b0;
          instr_valid_q <= 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_q <= S_HALT;
          mem_req_q <= 1'b0;
          halted_q <= 1'b1;
          fault_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        S_DECODE: begin
          state_q <= instr_q[INSTR_W-1 -: 4] == HALT_OP ? S_HALT : S_EXECUTE;
          halted_q <= instr_q[INSTR_W-1 -: 4] == HALT_OP;
        end
        S_EXECUTE: if (bus.exec_done_i) begin
          state_q <= S_FETCH;
          mem_req_q <= 1'b1;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  assign bus.fault_o = fault_q;
`else
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      mem_req_q <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start_i) begin
          state_q <= S_FETCH;
          mem_req_q <= 1'b1;
        end
        S_FETCH: if (bus.mem_ack_i) begin
          instr_q <= bus.mem_rdata_i;
          state_q <= S_DECODE;
          mem_req_q <= 1'b0;
          instr_valid_q <= 1'b1;
        end
        S_DECODE: begin
          state_q <= instr_q[INSTR_W-1 -: 4] == HALT_OP ? S_HALT : S_EXECUTE;
          halted_q <= instr_q[INSTR_W-1 -: 4] == HALT_OP;
        end
        S_EXECUTE: if (bus.exec_done_i) begin
          state_q <= S_FETCH;
          mem_req_q <= 1'b1;
        end
        default: ;
      endcase
    end
  assign bus.fault_o = 1'b0;
`endif
  assign bus.mem_req_o = mem_req_q;
  assign bus.mem_addr_o = pc;
  assign bus.pc_o = pc;
  assign bus.instr_o = instr_q;
  assign bus.instr_valid_o = instr_valid_q;
  assign bus.halted_o = halted_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer with a
// transaction-level reference model compared on every falling clock edge.
module tb_fetch_sequencer;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  fetch_sequencer_if #(.PC_W(8), .INSTR_W(16)) bus ();
  fetch_sequencer #(.PC_W(8), .INSTR_W(16), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: what the sequencer is doing, in terms of the rules only.
  typedef enum {M_IDLE, M_WAIT, M_DEC, M_EXEC, M_HALT} mode_t;
  mode_t mode;
  logic [7:0] m_pc;
  logic [15:0] m_instr;
  logic m_fault;
  int m_wait;
  always @(posedge clk or posedge rst)
    if (rst) begin
      mode <= M_IDLE;
      m_pc <= 8'd0;
      m_instr <= 16'd0;
      m_fault <= 1'b0;
      m_wait <= 0;
    end else
      case (mode)
        M_IDLE: if (bus.start_i) begin
          mode <= M_WAIT;
          m_wait <= 0;
        end
        M_WAIT: if (bus.mem_ack_i) begin
          m_instr <= bus.mem_rdata_i;
          mode <= M_DEC;
        end else begin
          m_wait <= m_wait + 1;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait + 1 >= TO) begin
            m_fault <= 1'b1;
            mode <= M_HALT;
          end
`endif
        end
        M_DEC: mode <= (int'(m_instr) / 4096) == 15 ? M_HALT : M_EXEC;
        M_EXEC: if (bus.exec_done_i) begin
          m_pc <= bus.branch_taken_i ? bus.branch_target_i : 8'((int'(m_pc) + 1) % 256);
          mode <= M_WAIT;
          m_wait <= 0;
        end
        default: ;
      endcase
  always @(negedge clk) begin
    chk("mem_req", bus.mem_req_o, mode == M_WAIT);
    chk("mem_addr", bus.mem_addr_o, m_pc);
    chk("pc", bus.pc_o, m_pc);
    chk("instr", bus.instr_o, m_instr);
    chk("instr_valid", bus.instr_valid_o, mode == M_DEC);
    chk("halted", bus.halted_o, mode == M_HALT);
    chk("fault", bus.fault_o, m_fault);
  end
  task automatic wait_req();
    int k = 0;
    while (bus.mem_req_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("req_timeout", bus.mem_req_o, 1);
  endtask
  // Ack the fetch after 'delay' waiting cycles; exec_done/branch held high
  // meanwhile must be ignored. Returns on the DECODE falling edge.
  task automatic fetch(input logic [15:0] data, input int delay);
    wait_req();
    repeat (delay) begin
      bus.exec_done_i = 1'b1;
      bus.branch_taken_i = 1'b1;
      bus.branch_target_i = 8'h77;
      @(negedge clk);
    end
    bus.exec_done_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    bus.mem_rdata_i = data;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 16'h0;
  endtask
  // Called on the DECODE falling edge; stray mem_acks with a HALT opcode must
  // be ignored. Returns on the first falling edge of the next FETCH.
  task automatic exec(input logic taken, input logic [7:0] target, input int delay);
    bus.mem_ack_i = 1'b1;
    bus.mem_rdata_i = 16'hFFFF;
    @(negedge clk);
    repeat (delay) @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 16'h0;
    bus.exec_done_i = 1'b1;
    bus.branch_taken_i = taken;
    bus.branch_target_i = target;
    @(negedge clk);
    bus.exec_done_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = 8'h0;
  endtask
  task automatic go();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 16'h0;
    bus.exec_done_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc_o, 8'h00);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_halted", bus.halted_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_req", bus.mem_req_o, 0);
    go();
    fetch(16'h1234, 0);
    chk("first_instr", bus.instr_o, 16'h1234);
    chk("first_valid", bus.instr_valid_o, 1);
    exec(1'b0, 8'h00, 0);
    chk("first_pc", bus.pc_o, 8'h01);
    chk("refetch_req", bus.mem_req_o, 1);
    chk("valid_single", bus.instr_valid_o, 0);
    fetch(16'h2000, 2);
    exec(1'b1, 8'h40, 1);
    chk("branch_addr", bus.mem_addr_o, 8'h40);
    fetch(16'h3000, 0);
    exec(1'b1, 8'hFF, 0);
    chk("pc_ff", bus.pc_o, 8'hFF);
    fetch(16'h4000, 1);
    exec(1'b0, 8'h00, 2);
    chk("pc_wrap", bus.pc_o, 8'h00);
    fetch(16'hF000, 0);
    @(negedge clk);
    chk("halt_flag", bus.halted_o, 1);
    chk("halt_no_req", bus.mem_req_o, 0);
    bus.start_i = 1'b1;
    bus.mem_ack_i = 1'b1;
    bus.mem_rdata_i = 16'h5555;
    bus.exec_done_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    bus.branch_target_i = 8'h55;
    repeat (5) @(negedge clk);
    chk("halt_stays", bus.halted_o, 1);
    chk("halt_pc", bus.pc_o, 8'h00);
    chk("halt_instr", bus.instr_o, 16'hF000);
    bus.start_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 16'h0;
    bus.exec_done_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = 8'h0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go();
    fetch(16'h1000, 0);
    exec(1'b1, 8'h05, 0);
    fetch(16'h2222, 0);
    @(negedge clk);
    chk("pre_rst_pc", bus.pc_o, 8'h05);
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc_o, 8'h00);
    chk("arst_instr", bus.instr_o, 16'h0);
    chk("arst_req", bus.mem_req_o, 0);
    chk("arst_valid", bus.instr_valid_o, 0);
    chk("arst_halted", bus.halted_o, 0);
    chk("arst_fault", bus.fault_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", bus.mem_req_o, 0);
    go();
    wait_req();
    repeat (TO - 1) @(negedge clk);
    chk("late_ack_req", bus.mem_req_o, 1);
    bus.mem_ack_i = 1'b1;
    bus.mem_rdata_i = 16'h2345;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 16'h0;
    chk("late_ack_valid", bus.instr_valid_o, 1);
    chk("late_ack_instr", bus.instr_o, 16'h2345);
    chk("late_ack_fault", bus.fault_o, 0);
    exec(1'b0, 8'h00, 0);
    repeat (TO - 1) @(negedge clk);
    chk("to_15_req", bus.mem_req_o, 1);
    chk("to_15_halted", bus.halted_o, 0);
    @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("to_16_fault", bus.fault_o, 1);
    chk("to_16_halted", bus.halted_o, 1);
`else
    chk("to_16_req", bus.mem_req_o, 1);
    chk("to_16_fault", bus.fault_o, 0);
`endif
    repeat (84) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("to_100_halted", bus.halted_o, 1);
    chk("to_100_req", bus.mem_req_o, 0);
`else
    chk("to_100_req", bus.mem_req_o, 1);
    chk("to_100_halted", bus.halted_o, 0);
`endif
    chk("to_100_pc", bus.pc_o, 8'h01);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
